clk_divider_multi: RTL and testbench

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

---
 rtl/clk_divider_multi.sv | 154 +++++++++++++++
 tb/tb_clk_divider_multi.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// clk_divider_multi
// -----------------
// Bank of independent programmable clock dividers, all running from one
// source clock. Each channel makes a registered square wave (clk_div) and a
// registered one-cycle pulse (tick) once per period. Divisor changes go
// through a pending register. The pending value only becomes active at the
// end of the channel's current period, so the output never glitches.
//
// Ports
//   clk_in   : source clock; all logic runs on its rising edge
//   rst      : synchronous, active-high reset
//   en       : global count enable (counters and clk_div hold while low)
//   sync     : restarts every channel at count 0 and applies any pending
//              divisor immediately
//   wr_en    : divisor write strobe
//   wr_ch    : channel index for the write; indices >= CHANNELS are ignored
//   wr_data  : new divisor value (0 stops the channel, 1 gives constant high)
//   clk_div  : per-channel divided square wave
//   tick     : per-channel pulse, high in the cycle after a period wraps
//   pending  : per-channel flag, high while a written divisor is not yet active
module clk_divider_multi #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 32,
    parameter int SRC_FREQ     = 100_000_000,
    parameter int DEFAULT_FREQ = 100,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    // Divisor loaded into every channel at reset.
    localparam logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(SRC_FREQ / DEFAULT_FREQ);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            localparam logic [CH_W-1:0] CH_IDX = CH_W'(gi);

            logic [WIDTH-1:0] cnt_reg;
            logic [WIDTH-1:0] cnt_next;
            logic [WIDTH-1:0] act_reg;
            logic [WIDTH-1:0] act_next;
            logic [WIDTH-1:0] pend_reg;
            logic [WIDTH-1:0] pend_next;
            logic             pending_reg;
            logic             pending_next;
            logic             div_reg;
            logic             div_next;
            logic             tick_reg;
            logic             tick_next;
            logic             hit;
            logic             wrap;

            // An out-of-range wr_ch never matches any generated index.
            // That is how writes to channels that do not exist are dropped.
            assign hit  = wr_en && (wr_ch == CH_IDX);

            // Last count of the period. The en and act != 0 conditions are
            // covered by the branch that uses this signal.
            assign wrap = (cnt_reg == (act_reg - WIDTH'(1)));

            always_comb begin
                cnt_next     = cnt_reg;
                act_next     = act_reg;
                pend_next    = pend_reg;
                pending_next = pending_reg;
                div_next     = div_reg;
                tick_next    = 1'b0;

                if (sync) begin
                    // Phase restart. A write on the same edge is applied
                    // straight away together with the restart.
                    cnt_next = '0;
                    div_next = 1'b0;
                    if (hit) begin
                        act_next     = wr_data;
                        pend_next    = wr_data;
                        pending_next = 1'b0;
                    end else if (pending_reg) begin
                        act_next     = pend_reg;
                        pending_next = 1'b0;
                    end
                end else if (act_reg == '0) begin
                    // Stopped channel. There is no running period to finish,
                    // so a new divisor takes effect immediately.
                    cnt_next = '0;
                    div_next = 1'b0;
                    if (hit) begin
                        act_next     = wr_data;
                        pend_next    = wr_data;
                        pending_next = 1'b0;
                    end
                end else begin
                    if (en) begin
                        if (wrap) begin
                            cnt_next  = '0;
                            tick_next = 1'b1;
                            // Divisor handover happens only here, on a
                            // period boundary. The value used is the one
                            // pending before this edge; a write on this
                            // same edge stays pending below.
                            if (pending_reg) begin
                                act_next     = pend_reg;
                                pending_next = 1'b0;
                            end
                        end else begin
                            cnt_next = cnt_reg + WIDTH'(1);
                        end
                        // Compare against the divisor that will be active
                        // after this edge. That way the first period after a
                        // handover already has the new duty split.
                        div_next = (cnt_next >= (act_next >> 1));
                    end
                    if (hit) begin
                        pend_next    = wr_data;
                        pending_next = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst) begin
                    cnt_reg     <= '0;
                    act_reg     <= DEFAULT_DIV;
                    pend_reg    <= DEFAULT_DIV;
                    pending_reg <= 1'b0;
                    div_reg     <= 1'b0;
                    tick_reg    <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    act_reg     <= act_next;
                    pend_reg    <= pend_next;
                    pending_reg <= pending_next;
                    div_reg     <= div_next;
                    tick_reg    <= tick_next;
                end
            end

            assign clk_div[gi] = div_reg;
            assign tick[gi]    = tick_reg;
            assign pending[gi] = pending_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi.
// Five channels, 16-bit counters, default divisor 1000/100 = 10.
module tb_clk_divider_multi;

    localparam int CH  = 5;
    localparam int W   = 16;
    localparam int CW  = 3;
    localparam int DEF = 10;

    logic          clk_in  = 1'b0;
    logic          rst     = 1'b1;
    logic          en      = 1'b0;
    logic          sync    = 1'b0;
    logic          wr_en   = 1'b0;
    logic [CW-1:0] wr_ch   = '0;
    logic [W-1:0]  wr_data = '0;
    logic [CH-1:0] clk_div;
    logic [CH-1:0] tick;
    logic [CH-1:0] pending;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk_in = ~clk_in;

    clk_divider_multi #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .SRC_FREQ    (1000),
        .DEFAULT_FREQ(100)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_data(wr_data),
        .clk_div(clk_div),
        .tick   (tick),
        .pending(pending)
    );

    // Reference model. It keeps each channel's position in its period plus
    // its divisors as plain integers, and updates them by the written rules.
    int m_pos  [CH];
    int m_act  [CH];
    int m_pend [CH];
    bit m_pflag[CH];
    bit m_div  [CH];
    bit m_tick [CH];

    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            bit wrote;
            wrote = wr_en && (int'(wr_ch) == i);
            if (rst) begin
                m_pos[i] = 0; m_act[i] = DEF; m_pend[i] = DEF;
                m_pflag[i] = 0; m_div[i] = 0; m_tick[i] = 0;
            end else if (sync) begin
                if (wrote) begin m_pend[i] = int'(wr_data); m_pflag[i] = 1; end
                if (m_pflag[i]) begin m_act[i] = m_pend[i]; m_pflag[i] = 0; end
                m_pos[i] = 0; m_div[i] = 0; m_tick[i] = 0;
            end else if (m_act[i] == 0) begin
                m_pos[i] = 0; m_div[i] = 0; m_tick[i] = 0;
                if (wrote) begin
                    m_act[i] = int'(wr_data); m_pend[i] = int'(wr_data); m_pflag[i] = 0;
                end
            end else begin
                if (en) begin
                    m_pos[i] = (m_pos[i] + 1) % m_act[i];
                    m_tick[i] = (m_pos[i] == 0);
                    if (m_tick[i] && m_pflag[i]) begin
                        m_act[i] = m_pend[i]; m_pflag[i] = 0;
                    end
                    m_div[i] = (m_pos[i] >= m_act[i] / 2);
                end else begin
                    m_tick[i] = 0;
                end
                if (wrote) begin m_pend[i] = int'(wr_data); m_pflag[i] = 1; end
            end
        end
    endfunction

    function automatic void check_vec(string name, logic [CH-1:0] got, logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cycle, got, exp);
        end
    endfunction

    function automatic void check_bit(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cycle, got, exp);
        end
    endfunction

    // One clock: the edge, model update, then compare every output.
    task automatic step();
        logic [CH-1:0] ed, et, ep;
        @(posedge clk_in);
        #1;
        cycle++;
        model_step();
        for (int i = 0; i < CH; i++) begin
            ed[i] = m_div[i]; et[i] = m_tick[i]; ep[i] = m_pflag[i];
        end
        check_vec("model_clk_div", clk_div, ed);
        check_vec("model_tick", tick, et);
        check_vec("model_pending", pending, ep);
    endtask

    task automatic write(int ch, int data);
        wr_en = 1'b1; wr_ch = CW'(ch); wr_data = W'(data);
        step();
        wr_en = 1'b0;
    endtask

    typedef struct {
        bit       en;
        bit       sync;
        bit       wr;
        int       data;
        bit       exp_div;
        bit       exp_tick;
        bit       exp_pend;
    } vec_t;

    function automatic vec_t mk(bit s, bit w, int d, bit xd, bit xt, bit xp);
        vec_t v;
        v.en = 1'b1; v.sync = s; v.wr = w; v.data = d;
        v.exp_div = xd; v.exp_tick = xt; v.exp_pend = xp;
        return v;
    endfunction

    vec_t tbl[31];

    initial begin
        int coinc[$];
        logic [CH-1:0] held;

        // Channel 0: divisor 4 plus sync, then 6 written mid-period,
        // then writes of 2 and 3, the second landing on a wrap edge.
        tbl[0]  = mk(0, 1, 4, 0, 0, 1);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 6, 1, 0, 1);
        tbl[12] = mk(0, 0, 0, 1, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 0, 0);
        tbl[18] = mk(0, 0, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 0, 0);
        tbl[23] = mk(0, 0, 0, 1, 0, 0);
        tbl[24] = mk(0, 1, 2, 1, 0, 1);
        tbl[25] = mk(0, 1, 3, 0, 1, 1);
        tbl[26] = mk(0, 0, 0, 1, 0, 1);
        tbl[27] = mk(0, 0, 0, 0, 1, 0);
        tbl[28] = mk(0, 0, 0, 1, 0, 0);
        tbl[29] = mk(0, 0, 0, 1, 0, 0);
        tbl[30] = mk(0, 1, 0, 0, 1, 0);
        tbl[30].wr = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check_vec("reset_clk_div", clk_div, '0);
        check_vec("reset_tick", tick, '0);
        check_vec("reset_pending", pending, '0);
        $display("reset: clk_div=%b tick=%b pending=%b", clk_div, tick, pending);
        rst = 1'b0;

        // Table-driven sequence on channel 0
        for (int r = 0; r < 31; r++) begin
            en = tbl[r].en; sync = tbl[r].sync;
            wr_en = tbl[r].wr; wr_ch = '0; wr_data = W'(tbl[r].data);
            step();
            check_bit("vec_clk_div0", clk_div[0], tbl[r].exp_div);
            check_bit("vec_tick0", tick[0], tbl[r].exp_tick);
            check_bit("vec_pending0", pending[0], tbl[r].exp_pend);
            $display("vec %0d: clk_div0=%b tick0=%b pending0=%b", r, clk_div[0], tick[0], pending[0]);
            sync = 1'b0; wr_en = 1'b0;
        end

        // en low for 10 cycles mid-period (channel 0 divisor 3, count 2)
        step();
        step();
        held = clk_div;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_vec("freeze_clk_div", clk_div, held);
            check_vec("freeze_tick", tick, '0);
        end
        en = 1'b1;
        step();
        check_bit("resume_tick0", tick[0], 1'b1);
        $display("en gap: held clk_div=%b, resumed tick0=%b", held, tick[0]);

        // Channel 1 divisor 5, then divisor 1
        write(1, 5);
        sync = 1'b1; step(); sync = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_bit("div5_clk_div1", clk_div[1], (k % 5) >= 2);
            check_bit("div5_tick1", tick[1], (k % 5) == 0);
        end
        write(1, 1);
        sync = 1'b1; step(); sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check_bit("div1_clk_div1", clk_div[1], 1'b1);
            check_bit("div1_tick1", tick[1], 1'b1);
        end
        $display("ch1: divisor 5 and divisor 1 sequences done");

        // Divisors 3 and 7 on channels 2 and 3, then coincident ticks
        write(2, 3);
        write(3, 7);
        sync = 1'b1; step(); sync = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (tick[2] && tick[3]) coinc.push_back(k);
        end
        checks++;
        if (coinc.size() != 2 || coinc[0] != 21 || coinc[1] != 42) begin
            errors++;
            $display("FAIL coincident_ticks: got %0d hits (first %0d), expected 2 hits at 21 and 42",
                     coinc.size(), (coinc.size() > 0) ? coinc[0] : -1);
        end
        $display("ch2/ch3: %0d coincident ticks", coinc.size());

        // Pending write, then reset together with en, sync and wr_en
        write(0, 8);
        check_bit("pend_before_rst", pending[0], 1'b1);
        rst = 1'b1; sync = 1'b1; wr_en = 1'b1; wr_ch = 3'd1; wr_data = 16'd3;
        step();
        rst = 1'b0; sync = 1'b0; wr_en = 1'b0;
        check_vec("rst_dom_clk_div", clk_div, '0);
        check_vec("rst_dom_tick", tick, '0);
        check_vec("rst_dom_pending", pending, '0);
        // A write to a channel index that does not exist is ignored.
        wr_en = 1'b1; wr_ch = 3'd5; wr_data = 16'd2;
        step();
        wr_en = 1'b0;
        check_vec("bad_ch_pending", pending, '0);
        for (int k = 2; k <= 20; k++) begin
            step();
            check_bit("default_clk_div0", clk_div[0], (k % DEF) >= DEF / 2);
            check_bit("default_tick0", tick[0], (k % DEF) == 0);
        end
        $display("reset dominance and default divisor sequence done");

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 499) == 0);
            sync    = ($urandom_range(0, 59) == 0);
            en      = ($urandom_range(0, 7) != 0);
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_ch   = CW'($urandom_range(0, 7));
            wr_data = W'($urandom_range(0, 12));
            step();
        end
        rst = 1'b0; sync = 1'b0; wr_en = 1'b0;
        $display("random: 3000 cycles compared against model");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
